// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control slice: sequencer states and register-index constants.
package pipe_ctrl_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef logic [REG_W-1:0] reg_idx_t;

   localparam logic [1:0] ST_FLUSH    = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;
   localparam logic [1:0] ST_ERROR    = 2'd3;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers of the instruction in ID.
// Purely combinational, zero latency; no flow control of its own.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic             i_id_uses_rt,
   input  logic [REG_W-1:0] i_ex_rt,
   input  logic             i_ex_mem_read,
   output logic             o_load_use
);

   logic w_rs_match;
   logic w_rt_match;

   assign w_rs_match = (i_ex_rt == i_id_rs);
   assign w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
   // A load into r0 never creates a real dependency.
   assign o_load_use = i_ex_mem_read && (i_ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-stage enables/flushes for load-use, taken branch and multi-cycle data memory.
// Controls act in the same cycle as their cause; a memory stall freezes every stage until ready or timeout.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT  = 16,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
)
(
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic             i_id_uses_rt,
   input  logic [REG_W-1:0] i_ex_rt,
   input  logic             i_ex_MemRead,
   input  logic             i_branch_taken,
   input  logic             i_mem_access,
   input  logic             i_dmem_ready,
   output logic             o_dmem_req,
   output logic             o_pc_en,
   output logic             o_if_id_en,
   output logic             o_if_id_flush,
   output logic             o_id_ex_en,
   output logic             o_id_ex_flush,
   output logic             o_ex_mem_en,
   output logic             o_mem_wb_en,
   output logic             o_mem_wb_bubble,
   output logic             o_mem_err,
   output logic [CNT_W-1:0] o_stall_cycles
);

   localparam logic [15:0] TMO        = 16'(MEM_TIMEOUT);
   localparam logic [3:0]  FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [15:0]      r_wait_cnt;
   logic [3:0]       r_flush_cnt;
   logic             r_mem_err;
   logic [CNT_W-1:0] r_stall;

   logic [1:0]  w_state_nxt;
   logic [15:0] w_wait_nxt;
   logic [3:0]  w_flush_nxt;
   logic        w_load_use;
   logic        w_advance;
   logic        w_count_stall;
   logic        w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
   logic        w_if_id_flush, w_id_ex_flush, w_mem_wb_bubble, w_dmem_req;

   hazard_detect u_hazard_detect (
      .i_id_rs       (i_id_rs),
      .i_id_rt       (i_id_rt),
      .i_id_uses_rt  (i_id_uses_rt),
      .i_ex_rt       (i_ex_rt),
      .i_ex_mem_read (i_ex_MemRead),
      .o_load_use    (w_load_use)
   );

   always_comb begin
      w_pc_en         = 1'b1;
      w_if_id_en      = 1'b1;
      w_id_ex_en      = 1'b1;
      w_ex_mem_en     = 1'b1;
      w_mem_wb_en     = 1'b1;
      w_if_id_flush   = 1'b0;
      w_id_ex_flush   = 1'b0;
      w_mem_wb_bubble = 1'b0;
      w_dmem_req      = 1'b0;
      w_advance       = 1'b0;
      w_state_nxt     = r_state;
      w_wait_nxt      = r_wait_cnt;
      w_flush_nxt     = r_flush_cnt;

      case (r_state)
         ST_FLUSH: begin
            w_pc_en         = 1'b0;
            w_if_id_flush   = 1'b1;
            w_id_ex_flush   = 1'b1;
            w_mem_wb_bubble = 1'b1;
            if (r_flush_cnt == FLUSH_LAST) begin
               w_state_nxt = ST_RUN;
               w_flush_nxt = 4'd0;
            end else begin
               w_flush_nxt = r_flush_cnt + 4'd1;
            end
         end
         ST_RUN: begin
            w_dmem_req = i_mem_access;
            if (i_mem_access && !i_dmem_ready) begin
               // Memory stall outranks branch/load-use; those are re-seen on release.
               w_state_nxt = ST_MEM_WAIT;
               w_wait_nxt  = 16'd1;
            end else begin
               w_advance = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            w_dmem_req = 1'b1;
            if (i_dmem_ready) begin
               w_advance   = 1'b1;
               w_state_nxt = ST_RUN;
            end else begin
               w_wait_nxt = r_wait_cnt + 16'd1;
               if (w_wait_nxt == TMO) begin
                  w_state_nxt = ST_ERROR;
               end
            end
         end
         default: begin
         end
      endcase

      if (!w_advance && r_state != ST_FLUSH) begin
         w_pc_en         = 1'b0;
         w_if_id_en      = 1'b0;
         w_id_ex_en      = 1'b0;
         w_ex_mem_en     = 1'b0;
         w_mem_wb_en     = 1'b0;
         w_mem_wb_bubble = 1'b1;
      end else if (w_advance && i_branch_taken) begin
         w_if_id_flush = 1'b1;
         w_id_ex_flush = 1'b1;
      end else if (w_advance && w_load_use) begin
         w_pc_en       = 1'b0;
         w_if_id_en    = 1'b0;
         w_id_ex_flush = 1'b1;
      end
   end

   assign w_count_stall = !w_pc_en && (r_state == ST_RUN || r_state == ST_MEM_WAIT);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= ST_FLUSH;
         r_wait_cnt  <= 16'd0;
         r_flush_cnt <= 4'd0;
         r_mem_err   <= 1'b0;
         r_stall     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_wait_cnt  <= w_wait_nxt;
         r_flush_cnt <= w_flush_nxt;
         if (w_state_nxt == ST_ERROR) begin
            r_mem_err <= 1'b1;
         end
         if (w_count_stall && (r_stall != {CNT_W{1'b1}})) begin
            r_stall <= r_stall + CNT_ONE;
         end
      end
   end

   assign o_dmem_req      = w_dmem_req;
   assign o_pc_en         = w_pc_en;
   assign o_if_id_en      = w_if_id_en;
   assign o_if_id_flush   = w_if_id_flush;
   assign o_id_ex_en      = w_id_ex_en;
   assign o_id_ex_flush   = w_id_ex_flush;
   assign o_ex_mem_en     = w_ex_mem_en;
   assign o_mem_wb_en     = w_mem_wb_en;
   assign o_mem_wb_bubble = w_mem_wb_bubble;
   assign o_mem_err       = r_mem_err;
   assign o_stall_cycles  = r_stall;

endmodule
